// File: rtl/axi4s_if.sv
// axi4s_if: AXI4-Stream bundle carrying tdata, tkeep, tlast with valid/ready handshake.
interface axi4s_if #(
    parameter int DATA_WIDTH = 64
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;
    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_receiver.sv
// axis_receiver: stream-to-FIFO writer with 2-entry skid buffer and overlength packet truncation.
module axis_receiver #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BEATS = 256,
    localparam int KEEP_W = DATA_WIDTH / 8,
    localparam int FIFO_W = DATA_WIDTH + KEEP_W + 1,
    localparam int CNT_W = $clog2(MAX_BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    axi4s_if.slave            axis,
    output logic [FIFO_W-1:0] fifo_wr_data,
    output logic              fifo_wr_en,
    input  logic              fifo_full,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic [CNT_W-1:0]  pkt_beats
);
    typedef enum logic [1:0] {IDLE, RECV, DISCARD} state_t;
    state_t             state;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [FIFO_W-1:0]  buf0;
    logic [FIFO_W-1:0]  buf1;
    logic [FIFO_W-1:0]  in_word;
    logic [1:0]         occ;
    logic [1:0]         occ_next;
    logic               tready_q;
    logic               accept;
    logic               store;
    logic               hit_max;
    always_comb begin
        accept = axis.tvalid && tready_q;
        cnt_inc = beat_cnt + CNT_W'(1);
        hit_max = state == RECV && cnt_inc == CNT_W'(MAX_BEATS);
        store = accept && state != DISCARD;
        in_word = {axis.tlast || hit_max, axis.tkeep, axis.tdata};
        fifo_wr_en = occ != 2'd0 && !fifo_full;
        fifo_wr_data = buf0;
        occ_next = occ + {1'b0, store} - {1'b0, fifo_wr_en};
    end
    assign axis.tready = tready_q;
    // buf0 is always the head; tready is registered from the next occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            occ <= 2'd0;
            tready_q <= 1'b1;
        end else begin
            occ <= occ_next;
            tready_q <= occ_next != 2'd2;
            if (fifo_wr_en)
                buf0 <= occ[1] ? buf1 : in_word;
            else if (store && occ == 2'd0)
                buf0 <= in_word;
            if (store && occ == 2'd1 && !fifo_wr_en)
                buf1 <= in_word;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            beat_cnt <= '0;
            pkt_beats <= '0;
            pkt_done <= 1'b0;
            pkt_err <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            pkt_err <= 1'b0;
            if (accept) begin
                case (state)
                    IDLE: begin
                        beat_cnt <= CNT_W'(1);
                        if (axis.tlast) begin
                            pkt_done <= 1'b1;
                            pkt_beats <= CNT_W'(1);
                        end else
                            state <= RECV;
                    end
                    RECV: begin
                        beat_cnt <= cnt_inc;
                        if (axis.tlast) begin
                            pkt_done <= 1'b1;
                            pkt_beats <= cnt_inc;
                            state <= IDLE;
                        end else if (hit_max)
                            state <= DISCARD;
                    end
                    default: begin
                        if (axis.tlast) begin
                            pkt_err <= 1'b1;
                            pkt_beats <= CNT_W'(MAX_BEATS);
                            state <= IDLE;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_axis_receiver.sv
// tb_axis_receiver: directed stimulus with a queue scoreboard checked by a negedge monitor.
module tb_axis_receiver;
    localparam int DW = 64;
    localparam int MB = 8;
    localparam int KW = DW / 8;
    localparam int FW = DW + KW + 1;
    localparam int CW = $clog2(MB + 1);
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_full = 1'b0;
    logic          fifo_wr_en;
    logic          pkt_done;
    logic          pkt_err;
    logic [FW-1:0] fifo_wr_data;
    logic [CW-1:0] pkt_beats;
    logic          store_flag = 1'b0;
    logic          rnd_full = 1'b0;
    logic          prev_store = 1'b0;
    logic          prev_last = 1'b0;
    logic          mon_acc;
    logic [CW:0]   ev;
    int            checks = 0;
    int            errors = 0;
    logic [FW-1:0] exp_q[$];
    logic [CW:0]   ev_q[$];
    axi4s_if #(.DATA_WIDTH(DW)) axis ();
    axis_receiver #(.DATA_WIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk(clk),
        .rst(rst),
        .axis(axis),
        .fifo_wr_data(fifo_wr_data),
        .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full),
        .pkt_done(pkt_done),
        .pkt_err(pkt_err),
        .pkt_beats(pkt_beats)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst) begin
            prev_store = 1'b0;
            prev_last = 1'b0;
        end else begin
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write: got %h expected no write", fifo_wr_data);
                end else
                    chk("fifo_word", fifo_wr_data, exp_q.pop_front());
            end
            if (fifo_full)
                chk("write_while_full", FW'(fifo_wr_en), FW'(0));
            if (prev_store && !fifo_full)
                chk("write_latency", FW'(fifo_wr_en), FW'(1));
            if (prev_last)
                chk("close_pulse_latency", FW'(pkt_done | pkt_err), FW'(1));
            if (pkt_done || pkt_err) begin
                if (ev_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_close: got done=%b err=%b beats=%0d expected none", pkt_done, pkt_err, pkt_beats);
                end else begin
                    ev = ev_q.pop_front();
                    chk("pkt_close", FW'({pkt_err, pkt_done, pkt_beats}), FW'({ev[CW], ~ev[CW], ev[CW-1:0]}));
                end
            end
            mon_acc = axis.tvalid && axis.tready;
            prev_store = mon_acc && store_flag;
            prev_last = mon_acc && axis.tlast;
        end
    end
    always @(posedge clk) if (rnd_full) #1 fifo_full = 1'($urandom_range(0, 1));
    task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic st, input bit rnd);
        do begin
            @(posedge clk);
            #1;
            axis.tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            axis.tdata = d;
            axis.tkeep = k;
            axis.tlast = l;
            store_flag = st;
            @(negedge clk);
        end while (!(axis.tvalid && axis.tready));
    endtask
    task automatic idle();
        @(posedge clk);
        #1;
        axis.tvalid = 1'b0;
        store_flag = 1'b0;
    endtask
    task automatic pkt(input int n, input logic [DW-1:0] base, input bit rnd);
        for (int i = 1; i <= n; i++) exp_q.push_back({i == n, {KW{1'b1}}, base + DW'(i)});
        ev_q.push_back({1'b0, CW'(n)});
        for (int i = 1; i <= n; i++) send(base + DW'(i), '1, i == n, 1'b1, rnd);
    endtask
    task automatic drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || ev_q.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || ev_q.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d words %0d closes pending expected 0", name, exp_q.size(), ev_q.size());
        end
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        int lens[6] = '{3, 1, 8, 5, 2, 7};
        axis.tvalid = 1'b0;
        axis.tdata = '0;
        axis.tkeep = '0;
        axis.tlast = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_tready", FW'(axis.tready), FW'(1));
        chk("reset_wr_en", FW'(fifo_wr_en), FW'(0));
        chk("reset_pulses", FW'({pkt_done, pkt_err}), FW'(0));
        chk("reset_pkt_beats", FW'(pkt_beats), FW'(0));
        pkt(4, 64'h0, 1'b0);
        idle();
        drain("four_beat");
        chk("four_beat_pkt_beats", FW'(pkt_beats), FW'(4));
        @(posedge clk);
        #1 fifo_full = 1'b1;
        fork
            pkt(6, 64'h10, 1'b0);
            begin
                repeat (5) @(negedge clk);
                chk("backpressure_tready", FW'(axis.tready), FW'(0));
                chk("backpressure_no_write", FW'(fifo_wr_en), FW'(0));
                @(posedge clk);
                #1 fifo_full = 1'b0;
            end
        join
        idle();
        drain("backpressure");
        chk("backpressure_pkt_beats", FW'(pkt_beats), FW'(6));
        for (int i = 1; i <= 8; i++) exp_q.push_back({i == 8, {KW{1'b1}}, 64'h20 + DW'(i)});
        ev_q.push_back({1'b1, CW'(MB)});
        for (int i = 1; i <= 12; i++) send(64'h20 + DW'(i), '1, i == 12, i <= 8, 1'b0);
        idle();
        drain("overlength");
        chk("overlength_pkt_beats", FW'(pkt_beats), FW'(8));
        exp_q.push_back({1'b1, 8'h0F, 64'hDEAD_BEEF_0123_4567});
        ev_q.push_back({1'b0, CW'(1)});
        send(64'hDEAD_BEEF_0123_4567, 8'h0F, 1'b1, 1'b1, 1'b0);
        idle();
        drain("single_beat");
        chk("single_beat_pkt_beats", FW'(pkt_beats), FW'(1));
        exp_q.push_back({1'b0, {KW{1'b1}}, 64'h31});
        send(64'h31, '1, 1'b0, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        @(posedge clk);
        #1 fifo_full = 1'b1;
        send(64'h32, '1, 1'b0, 1'b1, 1'b0);
        send(64'h33, '1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        axis.tvalid = 1'b0;
        store_flag = 1'b0;
        chk("hold_pkt_beats_mid_packet", FW'(pkt_beats), FW'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        fifo_full = 1'b0;
        @(negedge clk);
        chk("midreset_tready", FW'(axis.tready), FW'(1));
        chk("midreset_wr_en", FW'(fifo_wr_en), FW'(0));
        chk("midreset_pkt_beats", FW'(pkt_beats), FW'(0));
        pkt(2, 64'h40, 1'b0);
        idle();
        drain("after_reset");
        chk("after_reset_pkt_beats", FW'(pkt_beats), FW'(2));
        rnd_full = 1'b1;
        for (int p = 0; p < 6; p++) pkt(lens[p], 64'h100 * DW'(p + 1), 1'b1);
        idle();
        rnd_full = 1'b0;
        @(posedge clk);
        #2 fifo_full = 1'b0;
        drain("random");
        chk("random_pkt_beats", FW'(pkt_beats), FW'(7));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
